// File: rtl/gshare_predictor.sv
// gshare branch predictor: a PHT of saturating counters indexed by PC XOR the
// global history, a speculative GHR that is repaired on mispredict, and a
// saturating mispredict counter.
// Optional BTB is built when GSHARE_PREDICTOR_BTB_EN is defined.
module gshare_predictor #(
   parameter int IDX_W     = 10,
   parameter int GHR_LEN   = 8,
   parameter int CTR_WIDTH = 2,
   parameter int BTB_IDX_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_F,
   input  logic               branch_en_F,
   input  logic [31:0]        PC_F,
   output logic               BP_decision_F,
   output logic [GHR_LEN-1:0] ghr_snapshot_F,
   output logic               btb_hit_F,
   output logic [31:0]        target_F,
   input  logic               branch_en_EX,
   input  logic [31:0]        PC_EX,
   input  logic               branch_result,
   input  logic               BP_decision_EX,
   input  logic [GHR_LEN-1:0] ghr_snapshot_EX,
   input  logic [31:0]        target_EX,
   output logic               mispredict_EX,
   output logic [15:0]        mispredict_count
);

   localparam int PHT_DEPTH = 1 << IDX_W;
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

   logic [GHR_LEN-1:0]   ghr_reg;
   logic [GHR_LEN-1:0]   ghr_next;
   logic [GHR_LEN:0]     repair_hist;
   logic [GHR_LEN:0]     shift_hist;
   logic [CTR_WIDTH-1:0] pht_reg [PHT_DEPTH];
   logic [IDX_W-1:0]     lookup_idx;
   logic [IDX_W-1:0]     update_idx;
   logic [CTR_WIDTH-1:0] lookup_ctr;
   logic [CTR_WIDTH-1:0] update_ctr;
   logic [CTR_WIDTH-1:0] update_ctr_next;
   logic [15:0]          count_reg;

   // Lookup hashes with the speculative history, update with the history the
   // branch actually saw at fetch.
   assign lookup_idx     = PC_F[IDX_W+1:2] ^ IDX_W'(ghr_reg);
   assign update_idx     = PC_EX[IDX_W+1:2] ^ IDX_W'(ghr_snapshot_EX);
   assign lookup_ctr     = pht_reg[lookup_idx];
   assign update_ctr     = pht_reg[update_idx];
   assign BP_decision_F  = branch_en_F & lookup_ctr[CTR_WIDTH-1];
   assign ghr_snapshot_F = ghr_reg;
   assign mispredict_EX  = branch_en_EX & (branch_result ^ BP_decision_EX);
   assign mispredict_count = count_reg;

   // One extra bit lets the shift drop the oldest bit for any GHR_LEN, including 1.
   assign repair_hist = {ghr_snapshot_EX, branch_result};
   assign shift_hist  = {ghr_reg, BP_decision_F};

   // Next history: mispredict repair wins over the speculative fetch shift.
   always_comb begin
      ghr_next = ghr_reg;
      if (mispredict_EX)
         ghr_next = repair_hist[GHR_LEN-1:0];
      else if (branch_en_F && !stall_F)
         ghr_next = shift_hist[GHR_LEN-1:0];
   end

   // Saturating counter step for the resolving branch.
   always_comb begin
      update_ctr_next = update_ctr;
      if (branch_result && update_ctr != CTR_MAX)
         update_ctr_next = update_ctr + 1'b1;
      else if (!branch_result && update_ctr != '0)
         update_ctr_next = update_ctr - 1'b1;
   end

   // Speculative global history register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         ghr_reg <= '0;
      else
         ghr_reg <= ghr_next;
   end

   // Pattern history table; lookup reads the pre-update value (no bypass).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PHT_DEPTH; i++)
            pht_reg[i] <= CTR_INIT;
      end else if (branch_en_EX) begin
         pht_reg[update_idx] <= update_ctr_next;
      end
   end

   // Mispredict counter, sticks at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         count_reg <= '0;
      else if (mispredict_EX && count_reg != 16'hFFFF)
         count_reg <= count_reg + 16'd1;
   end

`ifdef GSHARE_PREDICTOR_BTB_EN
   localparam int BTB_DEPTH = 1 << BTB_IDX_W;
   localparam int TAG_W     = 30 - BTB_IDX_W;

   logic              btb_valid_reg  [BTB_DEPTH];
   logic [TAG_W-1:0]  btb_tag_reg    [BTB_DEPTH];
   logic [31:0]       btb_target_reg [BTB_DEPTH];
   logic [BTB_IDX_W-1:0] btb_rd_idx;
   logic [BTB_IDX_W-1:0] btb_wr_idx;
   logic              btb_wr_en;
   logic              unused_bits;

   assign btb_rd_idx  = PC_F[BTB_IDX_W+1:2];
   assign btb_wr_idx  = PC_EX[BTB_IDX_W+1:2];
   assign btb_wr_en   = branch_en_EX & branch_result;
   assign btb_hit_F   = branch_en_F & btb_valid_reg[btb_rd_idx]
                        & (btb_tag_reg[btb_rd_idx] == PC_F[31:BTB_IDX_W+2]);
   assign target_F    = btb_hit_F ? btb_target_reg[btb_rd_idx] : 32'd0;
   assign unused_bits = ^{PC_F[1:0], PC_EX[1:0]};

   // BTB valid bits; only these need reset, tag/target are qualified by them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BTB_DEPTH; i++)
            btb_valid_reg[i] <= 1'b0;
      end else if (btb_wr_en) begin
         btb_valid_reg[btb_wr_idx] <= 1'b1;
      end
   end

   // BTB tag and target storage, written by taken resolutions.
   always_ff @(posedge clk) begin
      if (btb_wr_en) begin
         btb_tag_reg[btb_wr_idx]    <= PC_EX[31:BTB_IDX_W+2];
         btb_target_reg[btb_wr_idx] <= target_EX;
      end
   end
`else
   logic unused_bits;

   assign btb_hit_F   = 1'b0;
   assign target_F    = 32'd0;
   assign unused_bits = ^{PC_F[31:IDX_W+2], PC_F[1:0], PC_EX[31:IDX_W+2],
                          PC_EX[1:0], target_EX, 32'(BTB_IDX_W)};
`endif

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 The module SHALL expose these parameters:
- IDX_W, 10, PHT index width (PHT depth = 2^IDX_W).
- GHR_LEN, 8, global history length; SHALL satisfy 1 <= GHR_LEN <= IDX_W.
- CTR_WIDTH, 2, saturating counter width; SHALL be 2 or 3.
- BTB_IDX_W, 6, BTB index width; used only when the configuration macro is defined.

REQ-002 The module SHALL expose these ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-low.
- stall_F  in  1  fetch stall; freezes speculative history.
- branch_en_F  in  1  fetch instruction is a conditional branch.
- PC_F  in  32  fetch PC.
- BP_decision_F  out  1  predicted taken.
- ghr_snapshot_F  out  GHR_LEN  history used for this lookup.
- btb_hit_F  out  1  BTB target valid.
- target_F  out  32  BTB predicted target.
- branch_en_EX  in  1  resolving instruction is a conditional branch.
- PC_EX  in  32  PC of the resolving branch.
- branch_result  in  1  actual outcome (1 = taken).
- BP_decision_EX  in  1  prediction that travelled with the branch.
- ghr_snapshot_EX  in  GHR_LEN  snapshot that travelled with the branch.
- target_EX  in  32  resolved taken target.
- mispredict_EX  out  1  resolution disagrees with prediction.
- mispredict_count  out  16  saturating mispredict counter.

Function
REQ-003 The PHT index SHALL be PC[IDX_W+1:2] XOR the zero-extended history.
- Lookup uses the speculative GHR.
- Update uses ghr_snapshot_EX.

REQ-004 BP_decision_F SHALL be combinational in the same cycle: the MSB of PHT[lookup index], gated by branch_en_F; it is 0 when branch_en_F=0.

REQ-005 ghr_snapshot_F SHALL equal the speculative GHR value used for the current lookup.

REQ-006 On each rising clk with branch_en_F=1 and stall_F=0, the speculative GHR SHALL shift left, inserting BP_decision_F at bit 0.

REQ-007 mispredict_EX SHALL equal branch_en_EX AND (branch_result XOR BP_decision_EX), combinationally.

REQ-008 When mispredict_EX=1, the next GHR SHALL be {ghr_snapshot_EX[GHR_LEN-2:0], branch_result}.
- This overrides any fetch-side shift in the same cycle.
- For GHR_LEN=1 the next GHR is branch_result.

REQ-009 When branch_en_EX=1, PHT[update index] SHALL update at the clock edge.
- Increment if branch_result=1, saturating at 2^CTR_WIDTH-1.
- Otherwise decrement, saturating at 0.

REQ-010 A lookup and an update to the same index in the same cycle SHALL NOT bypass: the lookup returns the pre-update value, and the new value is visible from the next cycle.

REQ-011 mispredict_count SHALL increment by 1 on each cycle with mispredict_EX=1 and hold at 16'hFFFF.

REQ-012 When branch_en_EX=0, PHT, BTB and mispredict_count SHALL hold.

REQ-013 Latency SHALL be:
- Lookup: 0 cycles.
- Update visible to lookup: 1 cycle.
- GHR repair visible to lookup: 1 cycle.

Reset
REQ-014 While rst=0, independent of clk:
- Every PHT counter resets to 2^(CTR_WIDTH-1)-1 (weakly not-taken).
- GHR resets to 0.
- mispredict_count resets to 0.
- All BTB valid bits reset to 0.

REQ-015 During reset, outputs SHALL be:
- BP_decision_F=0.
- ghr_snapshot_F=0.
- btb_hit_F=0.
- target_F=0.
- mispredict_EX follows its inputs combinationally.

REQ-016 Reset asserted mid-update SHALL discard the pending update; the first post-reset edge performs normal operation.

Configuration
REQ-017 Macro GSHARE_PREDICTOR_BTB_EN defined:
- A direct-mapped BTB of 2^BTB_IDX_W entries is built, each holding valid, tag PC[31:BTB_IDX_W+2] and a 32-bit target.
- Indexing is by PC[BTB_IDX_W+1:2].
- It is written when branch_en_EX=1 and branch_result=1, with target_EX.
- btb_hit_F = branch_en_F AND valid AND tag match.
- target_F = the stored target when btb_hit_F=1, else 0.
- Same-cycle write and read of one entry returns the old contents.

REQ-018 Macro GSHARE_PREDICTOR_BTB_EN undefined:
- No BTB storage is built.
- btb_hit_F and target_F are tied to 0.
- target_EX is ignored.

Verification
REQ-019 Reset-state lookup: release rst, then branch_en_F=1 with PC_F=0x100. Required: BP_decision_F=0 and ghr_snapshot_F=0.

REQ-020 Counter training: three EX updates, PC_EX=0x100, ghr_snapshot_EX=0, branch_result=1, with the fetch side idle. Required: the lookup at 0x100 with GHR=0 shows BP_decision_F=1, and the counter is saturated at 3.

REQ-021 Speculative shift and repair:
- Four fetch-side branches predicted 0 (with stall_F=0 throughout): GHR stays 0x00.
- Then a predicted-taken fetch, GHR=0x01, coinciding in the same cycle with an EX mispredict carrying ghr_snapshot_EX=0x05 and branch_result=1.
- Required: next GHR=0x0B and mispredict_count increments by 1.

REQ-022 Stall hold: branch_en_F=1 with stall_F=1 for 3 cycles. Required: GHR is unchanged.

REQ-023 Index collision: same-cycle lookup and update to the same index, counter starting at 1, branch_result=1. Required: BP_decision_F=0 in that cycle and 1 in the next.

REQ-024 BTB (macro defined): resolve a taken branch with PC_EX=0x200 and target_EX=0x340. Required: a fetch at 0x200 gives btb_hit_F=1 and target_F=0x340; a fetch at 0x200+(4<<BTB_IDX_W) gives btb_hit_F=0.
